keypad_scan_controller: RTL and testbench
=========================================

# keypad_scan_controller

Sequencing controller for the 4x4 matrix keypad. It drives the one-hot column strobe, dwells on each column long enough for the row lines to settle through a 2-flop synchronizer, and freezes the scan when a row responds. It then debounces press and release and delivers one encoded key code per physical press over a valid/ack handshake to the display/decoder logic. It replaces a free-running column rotator with a scan that stops on a candidate key and resumes after release.

## Interface
Parameters:
- DWELL, default 4: cycles each column is driven before rows are sampled; legal range 3..15.
- DEBOUNCE, default 4: consecutive stable cycles required to accept a press or a release; legal range 1..15.

Ports:
- slow_clk  input  1  scan clock (1 kHz); all logic on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- row_in  input  4  raw keypad rows; active-high, asynchronous to slow_clk.
- col_out  output  4  one-hot column drive; active-high.
- column_index  output  2  index of the bit set in col_out.
- key_code  output  4  accepted key, equal to {row_idx, col_idx}.
- key_valid  output  1  key_code is new; held until acknowledged.
- key_ack  input  1  consumer acknowledge; sampled only while key_valid=1.
- key_overrun  output  1  one-cycle pulse: an unacknowledged key was overwritten.

## Operation
- Reset values: col_out=4'b0001, column_index=0, key_code=0, key_valid=0, key_overrun=0, state=SCAN, dwell and debounce counters=0, synchronizer flops=0.
- row_in passes through a 2-flop synchronizer. In this section, "rows" means the synchronizer output.
- SCAN:
  - The dwell counter counts 0..DWELL-1 on the current column.
  - On count DWELL-1, with rows==0: rotate left (0001→0010→0100→1000→0001), increment column_index (wraps 3→0), and clear the dwell counter.
  - On count DWELL-1, with rows!=0: latch row_idx as the lowest-numbered set row bit (priority encoder), freeze the column, clear the debounce counter, and go to PRESS_DB.
- PRESS_DB:
  - While the latched row bit is 1, the debounce counter increments.
  - If the latched row bit is 0 on any cycle: abandon, advance to the next column, clear the dwell counter, go to SCAN.
  - When the counter reaches DEBOUNCE: load key_code={row_idx, column_index}, set key_valid, clear the counter, go to HOLD.
- HOLD: the column stays frozen.
  - A cycle with the latched row bit 0 increments the counter.
  - A cycle with the latched row bit 1 clears the counter.
  - When the counter reaches DEBOUNCE: advance to the next column, clear the dwell counter, go to SCAN.
  - Other row bits are ignored; multi-key presses yield only the priority key.
- Handshake:
  - key_valid rises on press acceptance.
  - key_ack=1 at an edge where key_valid=1 clears key_valid at that edge.
  - key_ack while key_valid=0 is ignored.
  - key_code holds until the next acceptance.
- Overrun: if acceptance happens while key_valid=1 and key_ack=0, key_code takes the new value, key_valid stays 1, and key_overrun pulses for one cycle.
- Acceptance and ack on the same edge: the new key wins. key_valid stays 1 with the new code, and there is no overrun.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any pending key is discarded.

## Timing
- col_out and column_index are registered and change together. Exactly one col_out bit is set at all times.
- In an idle scan, the column advances every DWELL cycles, so a full sweep takes 4·DWELL cycles.
- Row sampling point: DWELL-1 cycles after the column change. With DWELL≥3 this covers the 2-cycle synchronizer.
- Press latency, measured from the first sampling edge that sees the row: DEBOUNCE cycles until key_valid=1. key_valid is registered and visible one cycle after that edge.
- Minimum spacing between two accepted keys: DEBOUNCE (press) + DEBOUNCE (release) + DWELL cycles.
- key_overrun is high for exactly one cycle, coincident with the overwriting key_code update.

## Test plan
- Reset/idle: rst=0 then 1, row_in=0 → col_out 0001, 0010, 0100, 1000, 0001 at 4-cycle intervals; column_index 0,1,2,3,0; key_valid stays 0.
- Clean press on row 2 while column 1 is active, held 20 cycles then released; ack 2 cycles after valid → key_code=4'b1001, key_valid=1 4 cycles after the sampling edge, cleared the edge after ack. Column stays 0010 until 4 released cycles, then 0100.
- Bounce: row 1 asserted on column 3 for 2 cycles then dropped → no key_valid; scan resumes with col_out=0001.
- Multi-key: rows 0 and 3 both set on column 0 → key_code=4'b0000.
- Overrun: press/release key (r0,c2), then press key (r1,c0) with no ack → second acceptance gives key_code=4'b0100, key_valid stays 1, key_overrun=1 for one cycle. Repeat with ack on the acceptance edge → no overrun pulse.
- Async reset during HOLD with key_valid=1 → all outputs are at reset values before the next slow_clk edge; after release of rst, scanning restarts from column 0.

Source files
------------

// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller
// Scans a 4x4 matrix keypad one column at a time, freezes on a responding
// row, debounces press and release, and hands one key code per physical
// press to the consumer over a valid/ack handshake.

module keypad_scan_controller #(
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic       slow_clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [1:0] column_index,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_overrun
);

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
  localparam logic [3:0] DEB_LAST   = 4'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] dwell_cnt_r;
  logic [3:0] dwell_nxt_s;
  logic [3:0] db_cnt_r;
  logic [3:0] db_nxt_s;
  logic [1:0] row_idx_r;
  logic [1:0] column_index_r;
  logic [1:0] index_nxt_s;
  logic [3:0] col_out_r;
  logic [3:0] key_code_r;
  logic [3:0] code_nxt_s;
  logic       key_valid_r;
  logic       valid_nxt_s;
  logic       key_overrun_r;
  logic       overrun_nxt_s;
  logic [3:0] rows_s;
  logic       latched_bit_s;
  logic       dwell_done_s;
  logic       db_done_s;
  logic       advance_s;
  logic       accept_s;
  logic       latch_s;

  // Lowest-numbered active row wins when several keys share a column.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    if (rows[0]) begin
      lowest_row = 2'd0;
    end else if (rows[1]) begin
      lowest_row = 2'd1;
    end else if (rows[2]) begin
      lowest_row = 2'd2;
    end else begin
      lowest_row = 2'd3;
    end
  endfunction

  // Column strobe is decoded from the index so the two can never disagree.
  function automatic logic [3:0] col_decode(input logic [1:0] idx);
    case (idx)
      2'd0:    col_decode = 4'b0001;
      2'd1:    col_decode = 4'b0010;
      2'd2:    col_decode = 4'b0100;
      2'd3:    col_decode = 4'b1000;
      default: col_decode = 4'b0001;
    endcase
  endfunction

  assign rows_s        = sync2_r;
  assign latched_bit_s = sync2_r[row_idx_r];
  assign dwell_done_s  = (dwell_cnt_r == DWELL_LAST);
  assign db_done_s     = (db_cnt_r == DEB_LAST);

  // State register.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      state_r <= SCAN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision from dwell expiry and the latched row's debounce.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SCAN: begin
        if (dwell_done_s && (rows_s != 4'b0000)) begin
          state_nxt_s = PRESS_DB;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      PRESS_DB: begin
        if (!latched_bit_s) begin
          state_nxt_s = SCAN;
        end else if (db_done_s) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = PRESS_DB;
        end
      end
      HOLD: begin
        if (!latched_bit_s && db_done_s) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = SCAN;
    endcase
  end

  // Per-state counter updates plus the advance / latch / accept strobes.
  always_comb begin
    advance_s   = 1'b0;
    accept_s    = 1'b0;
    latch_s     = 1'b0;
    dwell_nxt_s = dwell_cnt_r;
    db_nxt_s    = db_cnt_r;
    case (state_r)
      SCAN: begin
        if (dwell_done_s) begin
          if (rows_s == 4'b0000) begin
            advance_s   = 1'b1;
            dwell_nxt_s = 4'd0;
          end else begin
            latch_s  = 1'b1;
            db_nxt_s = 4'd0;
          end
        end else begin
          dwell_nxt_s = dwell_cnt_r + 4'd1;
        end
      end
      PRESS_DB: begin
        if (!latched_bit_s) begin
          advance_s   = 1'b1;
          dwell_nxt_s = 4'd0;
        end else if (db_done_s) begin
          accept_s = 1'b1;
          db_nxt_s = 4'd0;
        end else begin
          db_nxt_s = db_cnt_r + 4'd1;
        end
      end
      HOLD: begin
        if (latched_bit_s) begin
          db_nxt_s = 4'd0;
        end else if (db_done_s) begin
          advance_s   = 1'b1;
          dwell_nxt_s = 4'd0;
        end else begin
          db_nxt_s = db_cnt_r + 4'd1;
        end
      end
      default: begin
        advance_s   = 1'b1;
        dwell_nxt_s = 4'd0;
        db_nxt_s    = 4'd0;
      end
    endcase
  end

  // Column index and handshake next values; a new key always beats an ack.
  always_comb begin
    code_nxt_s    = key_code_r;
    valid_nxt_s   = key_valid_r;
    overrun_nxt_s = 1'b0;
    if (advance_s) begin
      index_nxt_s = column_index_r + 2'd1;
    end else begin
      index_nxt_s = column_index_r;
    end
    if (accept_s) begin
      code_nxt_s    = {row_idx_r, column_index_r};
      valid_nxt_s   = 1'b1;
      overrun_nxt_s = key_valid_r & ~key_ack;
    end else if (key_valid_r && key_ack) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = key_valid_r;
    end
  end

  // Row synchronizer, counters, column drive and handshake registers.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      sync1_r        <= 4'b0000;
      sync2_r        <= 4'b0000;
      dwell_cnt_r    <= 4'd0;
      db_cnt_r       <= 4'd0;
      row_idx_r      <= 2'd0;
      column_index_r <= 2'd0;
      col_out_r      <= 4'b0001;
      key_code_r     <= 4'd0;
      key_valid_r    <= 1'b0;
      key_overrun_r  <= 1'b0;
    end else begin
      sync1_r        <= row_in;
      sync2_r        <= sync1_r;
      dwell_cnt_r    <= dwell_nxt_s;
      db_cnt_r       <= db_nxt_s;
      if (latch_s) begin
        row_idx_r <= lowest_row(rows_s);
      end else begin
        row_idx_r <= row_idx_r;
      end
      column_index_r <= index_nxt_s;
      col_out_r      <= col_decode(index_nxt_s);
      key_code_r     <= code_nxt_s;
      key_valid_r    <= valid_nxt_s;
      key_overrun_r  <= overrun_nxt_s;
    end
  end

  assign col_out      = col_out_r;
  assign column_index = column_index_r;
  assign key_code     = key_code_r;
  assign key_valid    = key_valid_r;
  assign key_overrun  = key_overrun_r;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Testbench for keypad_scan_controller: a simulated key matrix drives the
// rows from the column strobe, and a cycle-level reference model built from
// the scanning/debounce rules predicts every output on every clock.

module tb_keypad_scan_controller;

  localparam int DWELL    = 4;
  localparam int DEBOUNCE = 4;
  localparam int M_SCAN   = 0;
  localparam int M_PRESS  = 1;
  localparam int M_HOLD   = 2;

  logic       slow_clk = 1'b0;
  logic       rst      = 1'b1;
  logic [3:0] row_in   = 4'b0000;
  logic       key_ack  = 1'b0;
  logic [3:0] col_out;
  logic [1:0] column_index;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_overrun;

  int assert_count = 0;
  int fail_count   = 0;

  // Stimulus controls
  logic [15:0] keys = 16'h0000;   // bit r*4+c set = key (row r, col c) held
  bit          glitch_on = 1'b0;
  int          ack_mode = 0;      // 0 none, 1 random, 2 after two valid cycles, 3 on acceptance edge

  // Reference model state
  int         m_col, m_mode, m_since, m_run, m_row, m_valid_age;
  logic [3:0] m_s1, m_s2, m_code;
  logic       m_valid, m_ovr;

  keypad_scan_controller #(.DWELL(DWELL), .DEBOUNCE(DEBOUNCE)) dut (
    .slow_clk     (slow_clk),
    .rst          (rst),
    .row_in       (row_in),
    .col_out      (col_out),
    .column_index (column_index),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_ack      (key_ack),
    .key_overrun  (key_overrun)
  );

  initial forever #5 slow_clk = ~slow_clk;

  function automatic logic [3:0] matrix_rows(input logic [3:0] cols, input logic [15:0] k);
    logic [3:0] r;
    r = 4'b0000;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (cols[ci] && k[ri*4+ci]) r[ri] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_mode = M_SCAN; m_since = 0; m_run = 0; m_row = 0;
    m_s1 = 4'b0000; m_s2 = 4'b0000; m_code = 4'h0;
    m_valid = 1'b0; m_ovr = 1'b0; m_valid_age = 0;
  endtask

  // One clock of the keypad rules, applied to the inputs present at the edge.
  task automatic model_step(input logic [3:0] rin, input logic ack);
    logic [3:0] rows;
    bit adv, acc;
    int low;
    rows = m_s2;
    adv = 1'b0;
    acc = 1'b0;
    if (m_mode == M_SCAN) begin
      if (m_since == DWELL - 1) begin
        if (rows == 4'b0000) adv = 1'b1;
        else begin
          low = 0;
          while (!rows[low]) low++;
          m_row = low; m_run = 0; m_mode = M_PRESS;
        end
      end else m_since++;
    end else if (m_mode == M_PRESS) begin
      if (!rows[m_row]) adv = 1'b1;
      else if (m_run == DEBOUNCE - 1) begin acc = 1'b1; m_run = 0; m_mode = M_HOLD; end
      else m_run++;
    end else begin
      if (rows[m_row]) m_run = 0;
      else if (m_run == DEBOUNCE - 1) adv = 1'b1;
      else m_run++;
    end
    if (adv) begin m_col = (m_col + 1) % 4; m_since = 0; m_mode = M_SCAN; end
    m_ovr = acc && m_valid && !ack;
    if (acc) begin m_code = 4'(m_row * 4 + m_col); m_valid = 1'b1; end
    else if (m_valid && ack) m_valid = 1'b0;
    m_valid_age = !m_valid ? 0 : (acc ? 0 : m_valid_age + 1);
    m_s2 = m_s1;
    m_s1 = rin;
  endtask

  task automatic check_all();
    logic [3:0] ec;
    ec = 4'b0001 << m_col;
    chk("col_out", {4'h0, col_out}, {4'h0, ec});
    chk("column_index", {6'h0, column_index}, 8'(m_col));
    chk("key_code", {4'h0, key_code}, {4'h0, m_code});
    chk("key_valid", {7'h0, key_valid}, {7'h0, m_valid});
    chk("key_overrun", {7'h0, key_overrun}, {7'h0, m_ovr});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_col"}, {4'h0, col_out}, 8'h01);
    chk({tag, "_idx"}, {6'h0, column_index}, 8'h00);
    chk({tag, "_code"}, {4'h0, key_code}, 8'h00);
    chk({tag, "_valid"}, {7'h0, key_valid}, 8'h00);
    chk({tag, "_ovr"}, {7'h0, key_overrun}, 8'h00);
  endtask

  // Drive inputs, clock once, advance the model and compare everything.
  task automatic cycle();
    logic [3:0] g;
    g = 4'b0000;
    if (glitch_on && $urandom_range(0, 15) == 0) g = 4'(1 << $urandom_range(0, 3));
    row_in = matrix_rows(col_out, keys) ^ g;
    case (ack_mode)
      1: key_ack = ($urandom_range(0, 3) == 0);
      2: key_ack = m_valid && (m_valid_age >= 2);
      3: key_ack = (m_mode == M_PRESS) && (m_run == DEBOUNCE - 1) && m_s2[m_row];
      default: key_ack = 1'b0;
    endcase
    @(posedge slow_clk);
    model_step(row_in, key_ack);
    #1;
    check_all();
  endtask

  task automatic wait_mode(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (m_mode != target && n < budget) begin cycle(); n++; end
    chk({tag, "_reached"}, 8'(n < budget || m_mode == target), 8'h01);
  endtask

  task automatic wait_valid(input string tag, input logic want, input int budget);
    int n;
    n = 0;
    while (m_valid != want && n < budget) begin cycle(); n++; end
    chk({tag, "_reached"}, {7'h0, key_valid}, {7'h0, want});
  endtask

  task automatic wait_code(input string tag, input logic [3:0] code, input int budget);
    int n;
    n = 0;
    while (m_code != code && n < budget) begin cycle(); n++; end
    chk({tag, "_code"}, {4'h0, key_code}, {4'h0, code});
  endtask

  initial begin
    model_reset();
    // Reset asserted: outputs at reset values, also across a clock edge
    #1 rst = 1'b0;
    #1 check_reset_values("reset");
    @(posedge slow_clk); #1;
    check_reset_values("reset_hold");
    @(negedge slow_clk);
    rst = 1'b1;

    // Idle sweep: 4-cycle dwell per column, wraps after 16 cycles
    repeat (4) cycle();
    chk("idle_col1", {4'h0, col_out}, 8'h02);
    repeat (12) cycle();
    chk("idle_wrap_col", {4'h0, col_out}, 8'h01);
    chk("idle_wrap_idx", {6'h0, column_index}, 8'h00);

    // Clean press (row 2, col 1), acked two cycles after valid
    ack_mode = 2;
    keys = 16'h0200;
    repeat (20) cycle();
    chk("press_code", {4'h0, key_code}, 8'h09);
    chk("press_acked", {7'h0, key_valid}, 8'h00);
    chk("press_frozen", {4'h0, col_out}, 8'h02);
    keys = 16'h0000;
    repeat (5) cycle();
    chk("release_still_frozen", {4'h0, col_out}, 8'h02);
    cycle();
    chk("release_advance", {4'h0, col_out}, 8'h04);

    // Bounce: row 1 on column 3 dropped before the debounce completes
    ack_mode = 0;
    keys = 16'h0080;
    wait_mode("bounce_press", M_PRESS, 24);
    keys = 16'h0000;
    repeat (4) cycle();
    chk("bounce_no_valid", {7'h0, key_valid}, 8'h00);
    chk("bounce_resume_col", {4'h0, col_out}, 8'h01);

    // Multi-key on column 0: rows 0 and 3, lowest row wins
    keys = 16'h1001;
    wait_valid("multi", 1'b1, 40);
    chk("multi_code", {4'h0, key_code}, 8'h00);
    ack_mode = 2;
    keys = 16'h0000;
    wait_valid("multi_ack", 1'b0, 10);
    wait_mode("multi_release", M_SCAN, 20);

    // Overrun: (r0,c2) then (r1,c0) with no ack
    ack_mode = 0;
    keys = 16'h0004;
    wait_code("ovr_first", 4'h2, 60);
    keys = 16'h0000;
    wait_mode("ovr_first_release", M_SCAN, 20);
    keys = 16'h0010;
    wait_code("ovr_second", 4'h4, 60);
    chk("ovr_valid", {7'h0, key_valid}, 8'h01);
    chk("ovr_pulse", {7'h0, key_overrun}, 8'h01);
    cycle();
    chk("ovr_pulse_end", {7'h0, key_overrun}, 8'h00);
    keys = 16'h0000;
    wait_mode("ovr_second_release", M_SCAN, 20);

    // Same again with ack on the acceptance edge: new key wins, no overrun
    ack_mode = 3;
    keys = 16'h0004;
    wait_code("ackwin", 4'h2, 60);
    chk("ackwin_valid", {7'h0, key_valid}, 8'h01);
    chk("ackwin_no_ovr", {7'h0, key_overrun}, 8'h00);
    ack_mode = 2;
    keys = 16'h0000;
    wait_valid("ackwin_clear", 1'b0, 10);
    wait_mode("ackwin_release", M_SCAN, 20);

    // Asynchronous reset while holding an unacknowledged key
    ack_mode = 0;
    keys = 16'h8000;
    wait_mode("hold_reach", M_HOLD, 60);
    cycle();
    chk("hold_valid", {7'h0, key_valid}, 8'h01);
    #2 rst = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    keys = 16'h0000;
    @(negedge slow_clk);
    rst = 1'b1;
    repeat (4) cycle();
    chk("restart_col", {4'h0, col_out}, 8'h02);

    // Randomized key activity with row glitches and random acks
    glitch_on = 1'b1;
    ack_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 1) == 0) keys = 16'h0000;
        else keys = 16'(1 << $urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
